// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared checker states and default widths for the LFSR checker
package lfsr_pkg;
  typedef enum logic [1:0] {IDLE, SYNC, CHECK, DONE} state_t;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 32;
  localparam logic [31:0] DEF_TAPS = 32'h8020_0003;
endpackage

// File: rtl/lfsr_check_ctrl_if.sv
// lfsr_check_ctrl_if: control, data and status bundle of the LFSR checker
interface lfsr_check_ctrl_if import lfsr_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
);
  logic start;
  logic stop;
  logic [CNT_W-1:0] num_words;
  logic din_valid;
  logic [WIDTH-1:0] datain;
  logic busy;
  logic locked;
  logic done;
  logic [CNT_W-1:0] word_count;
  logic [CNT_W-1:0] error_count;
  logic error;
  modport master (
    output start, stop, num_words, din_valid, datain,
    input busy, locked, done, word_count, error_count, error
  );
  modport slave (
    input start, stop, num_words, din_valid, datain,
    output busy, locked, done, word_count, error_count, error
  );
endinterface

// File: rtl/lfsr.sv
// lfsr: one combinational Fibonacci step, feedback shifted in at bit 0
module lfsr import lfsr_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(DEF_TAPS)
) (
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  assign dout = {din[WIDTH-2:0], ^(din & TAPS)};
endmodule

// File: rtl/lfsr_check_ctrl.sv
// lfsr_check_ctrl: self-synchronising LFSR stream checker with lock tracking
module lfsr_check_ctrl import lfsr_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int LOCK_COUNT = 8,
  parameter int UNLOCK_COUNT = 4
) (
  input logic clk,
  input logic reset,
  lfsr_check_ctrl_if.slave bus
);
  localparam int RUN_W = $clog2((LOCK_COUNT > UNLOCK_COUNT ? LOCK_COUNT : UNLOCK_COUNT) + 1);
  state_t state, state_d;
  logic [WIDTH-1:0] prev, prev_d, pred;
  logic seeded, seeded_d, err, err_d, hit;
  logic [RUN_W-1:0] mrun, mrun_d, xrun, xrun_d;
  logic [CNT_W-1:0] wc, wc_d, ec, ec_d;
  lfsr #(.WIDTH(WIDTH)) u_lfsr (.din(prev), .dout(pred));
  assign hit = bus.datain == pred;
  assign bus.busy = state == SYNC || state == CHECK;
  assign bus.locked = state == CHECK;
  assign bus.done = state == DONE;
  assign bus.word_count = wc;
  assign bus.error_count = ec;
  assign bus.error = err;
  // state, predictor history, runs and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      prev <= '0;
      seeded <= 1'b0;
      mrun <= '0;
      xrun <= '0;
      wc <= '0;
      ec <= '0;
      err <= 1'b0;
    end else begin
      state <= state_d;
      prev <= prev_d;
      seeded <= seeded_d;
      mrun <= mrun_d;
      xrun <= xrun_d;
      wc <= wc_d;
      ec <= ec_d;
      err <= err_d;
    end
  end
  // next state; a valid word is always absorbed before stop takes effect
  always_comb begin
    state_d = state;
    prev_d = prev;
    seeded_d = seeded;
    mrun_d = mrun;
    xrun_d = xrun;
    wc_d = wc;
    ec_d = ec;
    err_d = err;
    case (state)
      IDLE, DONE: if (bus.start) begin
        state_d = SYNC;
        seeded_d = 1'b0;
        mrun_d = '0;
        xrun_d = '0;
        wc_d = '0;
        ec_d = '0;
        err_d = 1'b0;
      end
      SYNC: begin
        if (bus.din_valid) begin
          prev_d = bus.datain;
          seeded_d = 1'b1;
          if (seeded) mrun_d = hit ? mrun + RUN_W'(1) : '0;
          if (seeded && hit && mrun + RUN_W'(1) == RUN_W'(LOCK_COUNT)) begin
            state_d = CHECK;
            xrun_d = '0;
          end
        end
        if (bus.stop) state_d = DONE;
      end
      CHECK: begin
        if (bus.din_valid) begin
          prev_d = bus.datain;
          wc_d = wc + CNT_W'(1);
          xrun_d = hit ? '0 : xrun + RUN_W'(1);
          ec_d = hit || &ec ? ec : ec + CNT_W'(1);
          err_d = err || !hit;
          if (bus.num_words != '0 && wc_d == bus.num_words) state_d = DONE;
          else if (!hit && xrun + RUN_W'(1) == RUN_W'(UNLOCK_COUNT)) begin
            state_d = SYNC;
            mrun_d = '0;
          end
        end
        if (bus.stop) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: doc/lfsr_check_ctrl.md
LFSR_CHECK_CTRL -- requirements
Module: lfsr_check_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data word width.
REQ-002 SHALL have parameter CNT_W, default 32: width of counters and num_words.
REQ-003 SHALL have parameter LOCK_COUNT, default 8: consecutive matches needed to declare lock.
REQ-004 SHALL have parameter UNLOCK_COUNT, default 4: consecutive mismatches that drop lock.
REQ-005 Ports (reset reset, synchronous, active-high; clock clk):
  clk  input  1  clock
  reset  input  1  synchronous active-high reset
  start  input  1  single-cycle pulse, begins a test run
  stop  input  1  single-cycle pulse, aborts the run into DONE
  num_words  input  CNT_W  checked-word budget; 0 = continuous until stop
  din_valid  input  1  datain qualifier
  datain  input  WIDTH  received LFSR word
  busy  output  1  high in SYNC or CHECK
  locked  output  1  high in CHECK
  done  output  1  level, high in DONE
  word_count  output  CNT_W  valid words accepted in CHECK
  error_count  output  CNT_W  mismatches in CHECK, saturating
  error  output  1  sticky, set on first CHECK mismatch of a run

Function
REQ-006 States SHALL be IDLE, SYNC, CHECK, DONE; all outputs registered.
REQ-007 Prediction for each valid word SHALL be lfsr(previous valid word), i.e. self-synchronising; gaps in din_valid SHALL not disturb prediction.
REQ-008 IDLE: start -> SYNC; clear word_count, error_count, error, match/mismatch runs and seed flag.
REQ-009 SYNC: first valid word only seeds the predictor; each later valid word increments match_run on match, clears it on mismatch.
REQ-010 SYNC -> CHECK in the cycle after the valid word that brings match_run to LOCK_COUNT; locked rises with the state.
REQ-011 CHECK: each valid word increments word_count; a mismatch increments error_count (held at all-ones when saturated), sets error, increments mismatch_run; a match clears mismatch_run.
REQ-012 CHECK -> SYNC when mismatch_run reaches UNLOCK_COUNT; match_run cleared; predictor retains last word; counts and error held.
REQ-013 CHECK -> DONE on the valid word that makes word_count equal num_words (num_words != 0); that word is counted and compared.
REQ-014 stop in SYNC or CHECK -> DONE next cycle; a valid word in the same cycle is still processed first.
REQ-015 DONE holds counts and error; start in DONE behaves as in IDLE.
REQ-016 start in SYNC/CHECK and stop in IDLE/DONE SHALL be ignored.
REQ-017 Counter/status updates SHALL appear one cycle after the valid word that caused them.

Reset
REQ-018 reset SHALL force IDLE and clear busy, locked, done, error, word_count, error_count, runs and seed flag, in any state including mid-run; reset overrides start/stop.

Structure
REQ-019 State enum typedef and default WIDTH/CNT_W constants SHALL live in shared package lfsr_pkg.
REQ-020 Prediction SHALL instantiate the existing combinational lfsr module (WIDTH parameterised) as the single sub-module.

Verification
REQ-021 Clean sequence from seed 32'h1, num_words=16, start: locked after seed+8 matches, done after 16 CHECK words, word_count=16, error_count=0, error=0.
REQ-022 One word corrupted (bit 0 flipped) mid-CHECK: error_count=2 (word and successor), error=1, locked stays 1.
REQ-023 Four consecutive random words in CHECK: locked falls, state SYNC; clean stream re-locks after 8 matches; counts continue.
REQ-024 num_words=0, 100 clean words, stop: done=1, word_count = words seen in CHECK (91), busy=0.
REQ-025 din_valid toggled 1/0 every cycle on clean stream: no errors, lock after 9 valid words.
REQ-026 reset asserted mid-CHECK with start same cycle: next cycle all outputs 0, state IDLE.
